// File: rtl/fir_out_requant_if.sv
// AXI-Stream bundle used on both sides of the FIR output requantiser.
// The requantiser is a master on one instance and a slave on the other.
interface fir_out_requant_if #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
);
  logic signed [DATA_W-1:0] tdata;
  logic        [KEEP_W-1:0] tkeep;
  logic                     tlast;
  logic                     tvalid;
  logic                     tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/fir_out_requant.sv
// FIR output requantiser: 32-bit signed accumulator -> 16-bit signed, round half-up, shift, saturate.
// Optional saturation counter (sat_clr / sat_count) is compiled in when REQUANT_SAT_CNT_EN is defined.
module fir_out_requant #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic              clk,
  input  logic              reset,
  fir_out_requant_if.slave  s_axis,
  fir_out_requant_if.master m_axis
`ifdef REQUANT_SAT_CNT_EN
  ,
  input  logic              sat_clr,
  output logic [15:0]       sat_count
`endif
);

  // One extra bit of headroom so the largest positive input plus the rounding constant cannot wrap.
  localparam logic signed [IN_W:0]    RND    = (IN_W+1)'(1) <<< (SHIFT-1);
  localparam logic signed [IN_W:0]    MAX_Q  = (IN_W+1)'((2**(OUT_W-1))-1);
  localparam logic signed [IN_W:0]    MIN_Q  = -MAX_Q - (IN_W+1)'(1);
  localparam logic signed [OUT_W-1:0] SAT_HI = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] SAT_LO = {1'b1, {(OUT_W-1){1'b0}}};

  function automatic logic signed [IN_W:0] round_fn(input logic signed [IN_W-1:0] x);
    return {x[IN_W-1], x} + RND;
  endfunction

  function automatic logic sat_hit_fn(input logic signed [IN_W:0] r);
    logic signed [IN_W:0] q;
    q = r >>> SHIFT;
    return (q > MAX_Q) || (q < MIN_Q);
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_fn(input logic signed [IN_W:0] r);
    logic signed [IN_W:0] q;
    q = r >>> SHIFT;
    if (q > MAX_Q) return SAT_HI;
    if (q < MIN_Q) return SAT_LO;
    return q[OUT_W-1:0];
  endfunction

  logic                    vld_p1_q, vld_p1_d;
  logic signed [IN_W:0]    rnd_p1_q, rnd_p1_d;
  logic                    last_p1_q, last_p1_d;
  logic                    vld_p2_q, vld_p2_d;
  logic signed [OUT_W-1:0] dat_p2_q, dat_p2_d;
  logic                    last_p2_q, last_p2_d;
  logic                    adv1, adv2;
  logic                    unused_keep;

  assign unused_keep = ^s_axis.tkeep;

  // A stage may load when it is empty or when the stage after it is moving.
  assign adv2 = ~vld_p2_q | m_axis.tready;
  assign adv1 = ~vld_p1_q | adv2;

  always_comb begin
    vld_p1_d  = vld_p1_q;
    rnd_p1_d  = rnd_p1_q;
    last_p1_d = last_p1_q;
    vld_p2_d  = vld_p2_q;
    dat_p2_d  = dat_p2_q;
    last_p2_d = last_p2_q;
    // Stage 1: sign-extend and add the half-LSB rounding constant
    if (adv1) begin
      vld_p1_d = s_axis.tvalid;
      if (s_axis.tvalid) begin
        rnd_p1_d  = round_fn(s_axis.tdata);
        last_p1_d = s_axis.tlast;
      end
    end
    // Stage 2: arithmetic shift and saturate; data holds while the stage is empty
    if (adv2) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        dat_p2_d  = sat_fn(rnd_p1_q);
        last_p2_d = last_p1_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1_q  <= 1'b0;
      rnd_p1_q  <= '0;
      last_p1_q <= 1'b0;
      vld_p2_q  <= 1'b0;
      dat_p2_q  <= '0;
      last_p2_q <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      rnd_p1_q  <= rnd_p1_d;
      last_p1_q <= last_p1_d;
      vld_p2_q  <= vld_p2_d;
      dat_p2_q  <= dat_p2_d;
      last_p2_q <= last_p2_d;
    end
  end

  assign s_axis.tready = adv1;
  assign m_axis.tdata  = dat_p2_q;
  assign m_axis.tlast  = last_p2_q;
  assign m_axis.tvalid = vld_p2_q;
  assign m_axis.tkeep  = vld_p2_q ? '1 : '0;

`ifdef REQUANT_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Clear has priority; the count sticks at all-ones instead of wrapping.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr)
      sat_cnt_d = '0;
    else if (adv2 && vld_p1_q && sat_hit_fn(rnd_p1_q) && (sat_cnt_q != 16'hFFFF))
      sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: rounding, sign handling, saturation, backpressure, framing, reset.
// Saturation-counter checks are compiled in when REQUANT_SAT_CNT_EN is defined.
module tb_fir_out_requant;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  fir_out_requant_if #(.DATA_W(32), .KEEP_W(4)) s_if ();
  fir_out_requant_if #(.DATA_W(16), .KEEP_W(2)) m_if ();
`ifdef REQUANT_SAT_CNT_EN
  logic        sat_clr;
  logic [15:0] sat_count;
`endif

  fir_out_requant #(.IN_W(32), .OUT_W(16), .SHIFT(15)) dut (
    .clk    (clk),
    .reset  (reset),
    .s_axis (s_if),
    .m_axis (m_if)
`ifdef REQUANT_SAT_CNT_EN
    ,
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic test_reset();
    reset       = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = 4'hF;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
`ifdef REQUANT_SAT_CNT_EN
    sat_clr     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", m_if.tvalid); end
    total++; if (m_if.tdata !== 16'h0000) begin bad++; $display("FAIL reset_tdata got=%h want=0000", m_if.tdata); end
    total++; if (m_if.tkeep !== 2'b00) begin bad++; $display("FAIL reset_tkeep got=%b want=00", m_if.tkeep); end
    total++; if (m_if.tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b want=0", m_if.tlast); end
`ifdef REQUANT_SAT_CNT_EN
    total++; if (sat_count !== 16'h0000) begin bad++; $display("FAIL reset_satcnt got=%h want=0000", sat_count); end
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL release_tvalid got=%b want=0", m_if.tvalid); end
  endtask

  // Streams n samples back to back with tready=1; each output must show up two edges after its accept.
  task automatic test_direct(input string name, input int n,
                             input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    logic [31:0] din  [3];
    logic [15:0] dout [3];
    din[0] = d0; din[1] = d1; din[2] = d2;
    dout[0] = e0; dout[1] = e1; dout[2] = e2;
    m_if.tready = 1'b1;
    for (int i = 0; i < n + 2; i++) begin
      if (i >= 2) begin
        total++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== dout[i-2]) begin
          bad++;
          $display("FAIL %s_out%0d got vld=%b data=%h want vld=1 data=%h", name, i-2, m_if.tvalid, m_if.tdata, dout[i-2]);
        end
      end else begin
        total++;
        if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL %s_lat%0d got vld=%b want 0", name, i, m_if.tvalid); end
      end
      s_if.tvalid = (i < n);
      if (i < n) s_if.tdata = din[i];
      @(negedge clk);
    end
    s_if.tvalid = 1'b0;
    @(negedge clk);
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL %s_drain got vld=%b want 0", name, m_if.tvalid); end
  endtask

  task automatic test_saturation();
    test_direct("sat", 2, 32'h7FFFFFFF, 32'h80000000, 32'h0, 16'h7FFF, 16'h8000, 16'h0);
`ifdef REQUANT_SAT_CNT_EN
    total++; if (sat_count !== 16'd2) begin bad++; $display("FAIL sat_count got=%0d want=2", sat_count); end
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL sat_clear got=%0d want=0", sat_count); end
`endif
  endtask

  task automatic test_backpressure();
    int   in_idx  = 0;
    int   out_idx = 0;
    int   cyc     = 0;
    logic stalled = 1'b0;
    logic exp_rdy;
    logic [15:0] held = '0;
    while (out_idx < 10 && cyc < 60) begin
      m_if.tready = !(cyc >= 4 && cyc < 7);
      s_if.tvalid = (in_idx < 10);
      s_if.tdata  = 32'(in_idx) * 32'h8000;
      s_if.tlast  = 1'b0;
      #1;
      if (stalled) begin
        total++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== held) begin
          bad++; $display("FAIL bp_hold got vld=%b data=%h want vld=1 data=%h", m_if.tvalid, m_if.tdata, held);
        end
      end
      exp_rdy = ((in_idx - out_idx) < 2) || m_if.tready;
      total++;
      if (s_if.tready !== exp_rdy) begin bad++; $display("FAIL bp_sready cyc%0d got=%b want=%b", cyc, s_if.tready, exp_rdy); end
      if (m_if.tvalid && m_if.tready) begin
        total++;
        if (m_if.tdata !== out_idx[15:0]) begin bad++; $display("FAIL bp_data got=%h want=%h", m_if.tdata, out_idx[15:0]); end
        out_idx++;
      end
      stalled = m_if.tvalid && !m_if.tready;
      held    = m_if.tdata;
      if (s_if.tvalid && s_if.tready) in_idx++;
      @(negedge clk);
      cyc++;
    end
    total++; if (out_idx != 10) begin bad++; $display("FAIL bp_count got=%0d want=10", out_idx); end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_framing();
    int in_idx  = 0;
    int out_idx = 0;
    int cyc     = 0;
    while (out_idx < 6 && cyc < 200) begin
      m_if.tready = 1'($urandom_range(0, 1));
      s_if.tvalid = (in_idx < 6);
      s_if.tdata  = 32'(in_idx + 20) * 32'h8000;
      s_if.tlast  = (in_idx == 3);
      #1;
      if (m_if.tvalid) begin
        total++;
        if (m_if.tkeep !== 2'b11) begin bad++; $display("FAIL frame_keep got=%b want=11", m_if.tkeep); end
      end else begin
        total++;
        if (m_if.tkeep !== 2'b00) begin bad++; $display("FAIL frame_keep_idle got=%b want=00", m_if.tkeep); end
      end
      if (m_if.tvalid && m_if.tready) begin
        total++;
        if (m_if.tdata !== 16'(out_idx + 20) || m_if.tlast !== (out_idx == 3)) begin
          bad++;
          $display("FAIL frame_beat%0d got data=%h last=%b want data=%h last=%b",
                   out_idx, m_if.tdata, m_if.tlast, 16'(out_idx + 20), (out_idx == 3));
        end
        out_idx++;
      end
      if (s_if.tvalid && s_if.tready) in_idx++;
      @(negedge clk);
      cyc++;
    end
    total++; if (out_idx != 6) begin bad++; $display("FAIL frame_count got=%0d want=6", out_idx); end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'h00028000;
    @(negedge clk);
    s_if.tdata  = 32'h00030000;
    @(negedge clk);
    s_if.tvalid = 1'b0;
    total++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 16'h0005) begin
      bad++; $display("FAIL rstmid_pre got vld=%b data=%h want vld=1 data=0005", m_if.tvalid, m_if.tdata);
    end
    #2;
    reset = 1'b0;
    #1;
    total++; if (m_if.tvalid !== 1'b0 || m_if.tkeep !== 2'b00) begin
      bad++; $display("FAIL rstmid_async got vld=%b keep=%b want vld=0 keep=00", m_if.tvalid, m_if.tkeep);
    end
    @(negedge clk);
    reset       = 1'b1;
    m_if.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL rstmid_ghost%0d got vld=%b want 0", i, m_if.tvalid); end
    end
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'h00010000;
    @(negedge clk);
    s_if.tvalid = 1'b0;
    @(negedge clk);
    total++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 16'h0002) begin
      bad++; $display("FAIL rstmid_next got vld=%b data=%h want vld=1 data=0002", m_if.tvalid, m_if.tdata);
    end
  endtask

  initial begin
    test_reset();
    test_direct("round", 3, 32'h00004000, 32'h00003FFF, 32'h00008000, 16'h0001, 16'h0000, 16'h0001);
    test_direct("neg",   3, 32'hFFFFC000, 32'hFFFFBFFF, 32'hFFFF8000, 16'h0000, 16'hFFFF, 16'hFFFF);
    test_saturation();
    test_backpressure();
    test_framing();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
